serial_alu_seq: RTL and testbench

Bit-serial add/subtract sequencer that time-shares one 1-bit full-adder cell across a WIDTH-bit operation, one bit per clock, LSB first. It sits beside the CPU execute stage as the low-area arithmetic path for multi-cycle ops. It accepts operands through a valid/ready handshake and returns the result and flags through a second, independent valid/ready handshake.

---
 rtl/serial_alu_pkg.sv | 21 ++
 rtl/full_adder_1bit.sv | 13 +
 rtl/serial_alu_seq.sv | 148 ++++++++++++++
 tb/tb_serial_alu_seq.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_alu_pkg.sv
// Shared types and constants for the bit-serial add/subtract sequencer.
package serial_alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 16;

    // Signed limits for a width-bit result, right-aligned in 64 bits (width <= 64).
    function automatic logic [63:0] sat_pos_limit(input int width);
        sat_pos_limit = (64'd1 << (width - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_neg_limit(input int width);
        sat_neg_limit = 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/full_adder_1bit.sv
// One-bit full adder cell; the carry output is historically named Ovfl.
module full_adder_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic Ovfl
);

    assign s    = a ^ b ^ cin;
    assign Ovfl = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_alu_seq.sv
// Bit-serial add/subtract sequencer: one full-adder cell reused over WIDTH clocks, LSB first.
// Optional saturation on signed overflow is compiled in with SERIAL_ALU_SAT_EN.
module serial_alu_seq
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovfl,
    output logic             Zero
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t            state_r;
    logic [WIDTH-1:0]  sa_r;
    logic [WIDTH-1:0]  sb_r;
    logic [WIDTH-2:0]  sr_r;
    logic              carry_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              in_ready_r;
    logic              out_valid_r;
    logic [WIDTH-1:0]  sum_r;
    logic              cout_r;
    logic              ovfl_r;
    logic              zero_r;

    logic              fa_sum_s;
    logic              fa_co_s;
    logic [WIDTH-1:0]  sr_cat_s;
    logic              c_msb_s;
    logic              ovfl_s;
    logic [WIDTH-1:0]  res_s;

`ifdef SERIAL_ALU_SAT_EN
    localparam logic [63:0] SAT_POS_FULL = sat_pos_limit(WIDTH);
    localparam logic [63:0] SAT_NEG_FULL = sat_neg_limit(WIDTH);
    logic              a_sign_r;
`endif

    full_adder_1bit u_fa (
        .a    (sa_r[0]),
        .b    (sb_r[0]),
        .cin  (carry_r),
        .s    (fa_sum_s),
        .Ovfl (fa_co_s)
    );

    // On the last bit the carry flop holds the MSB carry-in, so the full result is the new bit over sr_r.
    assign sr_cat_s = {fa_sum_s, sr_r};
    assign c_msb_s  = carry_r;
    assign ovfl_s   = c_msb_s ^ fa_co_s;

    // Final result selection, with optional clamp to the signed limit on overflow.
    always_comb begin
        res_s = sr_cat_s;
`ifdef SERIAL_ALU_SAT_EN
        if (ovfl_s) begin
            res_s = a_sign_r ? SAT_NEG_FULL[WIDTH-1:0] : SAT_POS_FULL[WIDTH-1:0];
        end else begin
            res_s = sr_cat_s;
        end
`endif
    end

    // Sequencer FSM with datapath shift registers and registered handshake/result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            sa_r        <= '0;
            sb_r        <= '0;
            sr_r        <= '0;
            carry_r     <= 1'b0;
            cnt_r       <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            sum_r       <= '0;
            cout_r      <= 1'b0;
            ovfl_r      <= 1'b0;
            zero_r      <= 1'b0;
`ifdef SERIAL_ALU_SAT_EN
            a_sign_r    <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        sa_r       <= A;
                        sb_r       <= sub ? ~B : B;
                        carry_r    <= sub;
                        cnt_r      <= '0;
                        in_ready_r <= 1'b0;
                        state_r    <= RUN;
`ifdef SERIAL_ALU_SAT_EN
                        a_sign_r   <= A[WIDTH-1];
`endif
                    end
                end
                RUN: begin
                    sa_r    <= sa_r >> 1;
                    sb_r    <= sb_r >> 1;
                    sr_r    <= sr_cat_s[WIDTH-1:1];
                    carry_r <= fa_co_s;
                    cnt_r   <= cnt_r + CNT_W'(1);
                    if (cnt_r == LAST_CNT) begin
                        state_r     <= DONE;
                        out_valid_r <= 1'b1;
                        sum_r       <= res_s;
                        cout_r      <= fa_co_s;
                        ovfl_r      <= ovfl_s;
                        zero_r      <= (res_s == '0);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign Sum       = sum_r;
    assign Cout      = cout_r;
    assign Ovfl      = ovfl_r;
    assign Zero      = zero_r;

endmodule

// File: tb/tb_serial_alu_seq.sv
// Randomised bench for serial_alu_seq against an arithmetic reference model.
module tb_serial_alu_seq;

    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovfl;
        logic         zero;
    } res_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] Sum;
    logic         Cout;
    logic         Ovfl;
    logic         Zero;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    serial_alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Sum       (Sum),
        .Cout      (Cout),
        .Ovfl      (Ovfl),
        .Zero      (Zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: signed/unsigned integer arithmetic on the operand values.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        res_t   r;
        longint sa, sb, sres, ua, ub, smax, smin;
        logic [63:0] bits;
        sa   = $signed(a);
        sb   = $signed(b);
        ua   = longint'(a);
        ub   = longint'(b);
        smax = (longint'(1) << (W - 1)) - 1;
        smin = -(longint'(1) << (W - 1));
        sres = s ? (sa - sb) : (sa + sb);
        bits = sres;
        r.sum  = bits[W-1:0];
        r.cout = s ? (ua >= ub) : ((ua + ub) >= (longint'(1) << W));
        r.ovfl = (sres > smax) || (sres < smin);
`ifdef SERIAL_ALU_SAT_EN
        if (r.ovfl) begin
            bits  = (sa < 0) ? smin : smax;
            r.sum = bits[W-1:0];
        end
`endif
        r.zero = (r.sum == '0);
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Compare process: protocol, latency and result checked every cycle.
    bit   inflight = 1'b0;
    int   acc_cyc  = 0;
    res_t exp_op   = '0;
    res_t held     = '0;
    always @(negedge clk) begin
        res_t shown;
        bit   reached;
        if (!rst_n) begin
            check("rst_out_valid", out_valid, 0);
            check("rst_in_ready", in_ready, 1);
            check("rst_outputs", {Sum, Cout, Ovfl, Zero}, 0);
            inflight = 1'b0;
            held     = '0;
        end else begin
            reached = inflight && (cyc >= acc_cyc + W + 1);
            shown   = reached ? exp_op : held;
            if (inflight) begin
                check("out_valid_latency", out_valid, reached);
                check("in_ready_busy", in_ready, 0);
            end else begin
                check("out_valid_idle", out_valid, 0);
                check("in_ready_idle", in_ready, 1);
            end
            check("Sum", Sum, shown.sum);
            check("Cout", Cout, shown.cout);
            check("Ovfl", Ovfl, shown.ovfl);
            check("Zero", Zero, shown.zero);
            if (reached && out_ready) begin
                held     = exp_op;
                inflight = 1'b0;
            end else if (!inflight && in_valid) begin
                inflight = 1'b1;
                acc_cyc  = cyc;
                exp_op   = model(A, B, sub);
            end
        end
    end

    res_t got;

    // Issue one op, hold out_ready low for bp DONE cycles while pulsing in_valid, capture the result.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input int bp);
        int n;
        in_valid  = 1'b1;
        A         = a;
        B         = b;
        sub       = s;
        out_ready = (bp == 0);
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        A        = W'($urandom);
        B        = W'($urandom);
        n = 0;
        while (!out_valid && n < 3 * W) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) begin
            tests++;
            fails++;
            $display("FAIL out_valid_timeout: got 0, expected 1 within %0d cycles", 3 * W);
        end
        got = '{sum: Sum, cout: Cout, ovfl: Ovfl, zero: Zero};
        for (int k = 0; k < bp; k++) begin
            in_valid = 1'b1;
            A        = W'($urandom);
            B        = W'($urandom);
            sub      = 1'($urandom);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 4))
            0:       pick = '0;
            1:       pick = '1;
            2:       pick = {1'b0, {(W-1){1'b1}}};
            3:       pick = {1'b1, {(W-1){1'b0}}};
            default: pick = W'($urandom);
        endcase
    endfunction

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;
        sub       = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(16'h0003, 16'h0004, 1'b0, 0);
        check("add_3_4", got, {16'h0007, 1'b0, 1'b0, 1'b0});

        do_op(16'h7FFF, 16'h0001, 1'b0, 1);
`ifdef SERIAL_ALU_SAT_EN
        check("add_ovfl_sat", got, {16'h7FFF, 1'b0, 1'b1, 1'b0});
`else
        check("add_ovfl_wrap", got, {16'h8000, 1'b0, 1'b1, 1'b0});
`endif

        do_op(16'h0005, 16'h0005, 1'b1, 0);
        check("sub_5_5", got, {16'h0000, 1'b1, 1'b0, 1'b1});

        do_op(16'hFFFF, 16'h0001, 1'b0, 0);
        check("add_wrap_zero", got, {16'h0000, 1'b1, 1'b0, 1'b1});

        do_op(16'h1234, 16'h0F0F, 1'b1, 5);
        check("sub_backpressure", got, {16'h0325, 1'b1, 1'b0, 1'b0});

        // Abort an op with reset at RUN bit 8, then confirm a clean op afterwards.
        in_valid = 1'b1;
        A        = 16'hAAAA;
        B        = 16'h5555;
        sub      = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        do_op(16'h8000, 16'h0001, 1'b1, 0);
`ifdef SERIAL_ALU_SAT_EN
        check("post_reset_sub", got, {16'h8000, 1'b1, 1'b1, 1'b0});
`else
        check("post_reset_sub", got, {16'h7FFF, 1'b1, 1'b1, 1'b0});
`endif

        for (int i = 0; i < 40; i++) begin
            do_op(pick(), pick(), 1'($urandom), $urandom_range(0, 3));
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
